// File: rtl/kf8255_handshake_ctrl_if.sv
// kf8255_handshake_ctrl_if: CPU-side pulses, peripheral strobes and port-stage/status outputs of one 8255 handshake group
interface kf8255_handshake_ctrl_if;
  logic [1:0] mode_select_reg;
  logic       port_io_reg;
  logic       update_mode;
  logic       wr_start;
  logic       wr_end;
  logic       rd_start;
  logic       rd_end;
  logic       inte_in_wr;
  logic       inte_out_wr;
  logic       inte_data;
  logic       stb_n;
  logic       ack_n;
  logic       strobe;
  logic       hiz;
  logic       ibf;
  logic       obf_n;
  logic       intr;
  logic       inte_in;
  logic       inte_out;
  modport master (
    output mode_select_reg, port_io_reg, update_mode, wr_start, wr_end, rd_start, rd_end,
           inte_in_wr, inte_out_wr, inte_data, stb_n, ack_n,
    input  strobe, hiz, ibf, obf_n, intr, inte_in, inte_out
  );
  modport slave (
    input  mode_select_reg, port_io_reg, update_mode, wr_start, wr_end, rd_start, rd_end,
           inte_in_wr, inte_out_wr, inte_data, stb_n, ack_n,
    output strobe, hiz, ibf, obf_n, intr, inte_in, inte_out
  );
endinterface

// File: rtl/kf8255_handshake_ctrl.sv
// kf8255_handshake_ctrl: 8255 mode 1/2 handshake and port C status for one group; KF8255_HS_SYNC_EN selects SYNC_STAGES-deep strobe/ack synchronizers, otherwise a single sampling flop
module kf8255_handshake_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input logic                     clock,
  input logic                     reset,
  kf8255_handshake_ctrl_if.slave  bus
);
`ifdef KF8255_HS_SYNC_EN
  localparam int NS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
`else
  localparam int NS = 1;
`endif
  logic [NS-1:0] stb_sync_q, stb_sync_d, ack_sync_q, ack_sync_d;
  logic          stb_prev_q, stb_prev_d, ack_prev_q, ack_prev_d;
  logic          ibf_q, ibf_d, obf_n_q, obf_n_d;
  logic          pend_in_q, pend_in_d, pend_out_q, pend_out_d;
  logic          inte_in_q, inte_in_d, inte_out_q, inte_out_d;
  logic [NS:0]   stb_chain, ack_chain;
  logic          stb_s, ack_s, stb_fall, stb_rise, ack_fall, ack_rise;
  logic          mode2, in_en, out_en;
  assign mode2     = bus.mode_select_reg[1];
  assign in_en     = mode2 | (bus.mode_select_reg == 2'b01 & bus.port_io_reg);
  assign out_en    = mode2 | (bus.mode_select_reg == 2'b01 & ~bus.port_io_reg);
  assign stb_chain = {stb_sync_q, bus.stb_n};
  assign ack_chain = {ack_sync_q, bus.ack_n};
  assign stb_s     = stb_chain[NS];
  assign ack_s     = ack_chain[NS];
  assign stb_fall  = stb_prev_q & ~stb_s;
  assign stb_rise  = ~stb_prev_q & stb_s;
  assign ack_fall  = ack_prev_q & ~ack_s;
  assign ack_rise  = ~ack_prev_q & ack_s;
  // next state: synchronizers shift freely; control-word write overrides every status flag
  always_comb begin
    stb_sync_d = stb_chain[NS-1:0];
    ack_sync_d = ack_chain[NS-1:0];
    stb_prev_d = stb_s;
    ack_prev_d = ack_s;
    ibf_d      = bus.update_mode ? 1'b0 : (in_en & stb_fall) ? 1'b1 : bus.rd_end ? 1'b0 : ibf_q;
    obf_n_d    = bus.update_mode ? 1'b1 : (out_en & bus.wr_end) ? 1'b0 : (out_en & ack_fall) ? 1'b1 : obf_n_q;
    pend_in_d  = bus.update_mode ? 1'b0 : (in_en & stb_rise & (ibf_q | stb_fall)) ? 1'b1 :
                 bus.rd_start ? 1'b0 : pend_in_q;
    pend_out_d = bus.update_mode ? 1'b0 : (out_en & ack_rise & obf_n_d) ? 1'b1 :
                 bus.wr_start ? 1'b0 : pend_out_q;
    inte_in_d  = bus.update_mode ? 1'b0 : bus.inte_in_wr ? bus.inte_data : inte_in_q;
    inte_out_d = bus.update_mode ? 1'b0 : bus.inte_out_wr ? bus.inte_data : inte_out_q;
  end
  // state register on the falling clock edge; strobe/ack history resets inactive-high
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stb_sync_q <= '1;
      ack_sync_q <= '1;
      stb_prev_q <= 1'b1;
      ack_prev_q <= 1'b1;
      ibf_q      <= 1'b0;
      obf_n_q    <= 1'b1;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      inte_in_q  <= 1'b0;
      inte_out_q <= 1'b0;
    end else begin
      stb_sync_q <= stb_sync_d;
      ack_sync_q <= ack_sync_d;
      stb_prev_q <= stb_prev_d;
      ack_prev_q <= ack_prev_d;
      ibf_q      <= ibf_d;
      obf_n_q    <= obf_n_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      inte_in_q  <= inte_in_d;
      inte_out_q <= inte_out_d;
    end
  end
  // outputs: port-stage controls follow the synchronized strobes, intr is masked live by INTE
  always_comb begin
    bus.strobe   = in_en & ~stb_s;
    bus.hiz      = ~(mode2 & ~ack_s);
    bus.ibf      = ibf_q;
    bus.obf_n    = obf_n_q;
    bus.intr     = (inte_in_q & pend_in_q) | (inte_out_q & pend_out_q);
    bus.inte_in  = inte_in_q;
    bus.inte_out = inte_out_q;
  end
endmodule

// File: tb/tb_kf8255_handshake_ctrl.sv
// tb_kf8255_handshake_ctrl: directed vector table plus handshake sequences for kf8255_handshake_ctrl
module tb_kf8255_handshake_ctrl;
  localparam int SS = 2;
`ifdef KF8255_HS_SYNC_EN
  localparam int L = SS;
`else
  localparam int L = 1;
`endif
  typedef struct {
    logic [1:0] mode;
    logic       pio;
    logic       stb_n;
    logic       ack_n;
    logic       exp_strobe;
    logic       exp_hiz;
  } vec_t;
  logic clock = 1'b1;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs [9];
  kf8255_handshake_ctrl_if bus ();
  kf8255_handshake_ctrl #(.SYNC_STAGES(SS)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b", name, act, exp);
    end
  endtask
  task automatic pulse_um();
    bus.update_mode = 1'b1;
    tick();
    bus.update_mode = 1'b0;
  endtask
  task automatic set_inte(input logic in_wr, input logic out_wr, input logic d);
    bus.inte_in_wr = in_wr;
    bus.inte_out_wr = out_wr;
    bus.inte_data = d;
    tick();
    bus.inte_in_wr = 1'b0;
    bus.inte_out_wr = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  initial begin
    vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.mode_select_reg = 2'b00;
    bus.port_io_reg = 1'b0;
    bus.update_mode = 1'b0;
    bus.wr_start = 1'b0;
    bus.wr_end = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_end = 1'b0;
    bus.inte_in_wr = 1'b0;
    bus.inte_out_wr = 1'b0;
    bus.inte_data = 1'b0;
    bus.stb_n = 1'b1;
    bus.ack_n = 1'b1;
    tick();
    tick();
    chk("rst_strobe", bus.strobe, 1'b0);
    chk("rst_hiz", bus.hiz, 1'b1);
    chk("rst_ibf", bus.ibf, 1'b0);
    chk("rst_obf_n", bus.obf_n, 1'b1);
    chk("rst_intr", bus.intr, 1'b0);
    chk("rst_inte_in", bus.inte_in, 1'b0);
    chk("rst_inte_out", bus.inte_out, 1'b0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      bus.mode_select_reg = vecs[i].mode;
      bus.port_io_reg = vecs[i].pio;
      bus.stb_n = vecs[i].stb_n;
      bus.ack_n = vecs[i].ack_n;
      repeat (L + 1) tick();
      chk($sformatf("vec%0d_strobe", i), bus.strobe, vecs[i].exp_strobe);
      chk($sformatf("vec%0d_hiz", i), bus.hiz, vecs[i].exp_hiz);
    end
    bus.stb_n = 1'b1;
    bus.ack_n = 1'b1;
    repeat (L + 1) tick();
    do_reset();
    // mode 1 input handshake
    bus.mode_select_reg = 2'b01;
    bus.port_io_reg = 1'b1;
    pulse_um();
    set_inte(1'b1, 1'b0, 1'b1);
    chk("m1i_inte_in", bus.inte_in, 1'b1);
    bus.stb_n = 1'b0;
    repeat (L) tick();
    chk("m1i_strobe_on", bus.strobe, 1'b1);
    chk("m1i_ibf_not_yet", bus.ibf, 1'b0);
    tick();
    chk("m1i_ibf_set", bus.ibf, 1'b1);
    bus.stb_n = 1'b1;
    repeat (L) tick();
    chk("m1i_strobe_off", bus.strobe, 1'b0);
    chk("m1i_intr_not_yet", bus.intr, 1'b0);
    tick();
    chk("m1i_intr_set", bus.intr, 1'b1);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    chk("m1i_intr_rd_start", bus.intr, 1'b0);
    chk("m1i_ibf_held", bus.ibf, 1'b1);
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    chk("m1i_ibf_rd_end", bus.ibf, 1'b0);
    // mode 1 output handshake
    bus.port_io_reg = 1'b0;
    pulse_um();
    set_inte(1'b0, 1'b1, 1'b1);
    chk("m1o_inte_out", bus.inte_out, 1'b1);
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    chk("m1o_obf_low", bus.obf_n, 1'b0);
    chk("m1o_intr_idle", bus.intr, 1'b0);
    bus.ack_n = 1'b0;
    repeat (L) tick();
    chk("m1o_obf_not_yet", bus.obf_n, 1'b0);
    chk("m1o_hiz_mode1", bus.hiz, 1'b1);
    tick();
    chk("m1o_obf_high", bus.obf_n, 1'b1);
    bus.ack_n = 1'b1;
    repeat (L) tick();
    chk("m1o_intr_not_yet", bus.intr, 1'b0);
    tick();
    chk("m1o_intr_set", bus.intr, 1'b1);
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    chk("m1o_intr_wr_start", bus.intr, 1'b0);
    // mode 2 bidirectional
    bus.mode_select_reg = 2'b10;
    pulse_um();
    set_inte(1'b1, 1'b1, 1'b1);
    bus.ack_n = 1'b0;
    repeat (L) tick();
    chk("m2_hiz_drive", bus.hiz, 1'b0);
    bus.ack_n = 1'b1;
    repeat (L) tick();
    chk("m2_hiz_release", bus.hiz, 1'b1);
    tick();
    chk("m2_intr_out", bus.intr, 1'b1);
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    chk("m2_intr_out_clr", bus.intr, 1'b0);
    bus.stb_n = 1'b0;
    repeat (L + 1) tick();
    chk("m2_ibf_set", bus.ibf, 1'b1);
    bus.stb_n = 1'b1;
    repeat (L + 1) tick();
    chk("m2_intr_in", bus.intr, 1'b1);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    chk("m2_intr_in_clr", bus.intr, 1'b0);
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    chk("m2_ibf_clr", bus.ibf, 1'b0);
    // INTE masking of a pending input flag
    bus.mode_select_reg = 2'b01;
    bus.port_io_reg = 1'b1;
    pulse_um();
    bus.stb_n = 1'b0;
    repeat (L + 1) tick();
    bus.stb_n = 1'b1;
    repeat (L + 1) tick();
    chk("mask_ibf", bus.ibf, 1'b1);
    chk("mask_intr_off", bus.intr, 1'b0);
    set_inte(1'b1, 1'b0, 1'b1);
    chk("mask_intr_on", bus.intr, 1'b1);
    set_inte(1'b1, 1'b0, 1'b0);
    chk("mask_intr_masked", bus.intr, 1'b0);
    // stb fall coincides with rd_end: set wins
    bus.stb_n = 1'b0;
    repeat (L) tick();
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    chk("coll_ibf", bus.ibf, 1'b1);
    bus.stb_n = 1'b1;
    repeat (L + 1) tick();
    set_inte(1'b1, 1'b0, 1'b1);
    chk("coll_intr", bus.intr, 1'b1);
    pulse_um();
    chk("um_ibf", bus.ibf, 1'b0);
    chk("um_intr", bus.intr, 1'b0);
    chk("um_obf_n", bus.obf_n, 1'b1);
    chk("um_inte_in", bus.inte_in, 1'b0);
    // wr_end coincides with ack fall: wr_end wins
    bus.port_io_reg = 1'b0;
    pulse_um();
    bus.ack_n = 1'b0;
    repeat (L) tick();
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    chk("coll_obf_n", bus.obf_n, 1'b0);
    bus.ack_n = 1'b1;
    repeat (L + 1) tick();
    set_inte(1'b0, 1'b1, 1'b1);
    chk("coll_no_pend_out", bus.intr, 1'b0);
    // mode 0 ignores all handshake activity
    bus.mode_select_reg = 2'b00;
    pulse_um();
    bus.stb_n = 1'b0;
    bus.ack_n = 1'b0;
    repeat (L + 1) tick();
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    chk("m0_strobe", bus.strobe, 1'b0);
    chk("m0_hiz", bus.hiz, 1'b1);
    chk("m0_ibf", bus.ibf, 1'b0);
    chk("m0_obf_n", bus.obf_n, 1'b1);
    bus.stb_n = 1'b1;
    bus.ack_n = 1'b1;
    repeat (L + 1) tick();
    set_inte(1'b1, 1'b1, 1'b1);
    chk("m0_intr", bus.intr, 1'b0);
    // async reset mid-handshake
    bus.mode_select_reg = 2'b01;
    bus.port_io_reg = 1'b1;
    pulse_um();
    set_inte(1'b1, 1'b0, 1'b1);
    bus.stb_n = 1'b0;
    repeat (L + 1) tick();
    chk("mid_ibf", bus.ibf, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ibf", bus.ibf, 1'b0);
    chk("mid_rst_strobe", bus.strobe, 1'b0);
    chk("mid_rst_inte_in", bus.inte_in, 1'b0);
    bus.stb_n = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kf8255_handshake_ctrl.md
Name: kf8255_handshake_ctrl

Overview:
Mode 1/2 handshake controller for one 8255 group (A or B). It takes the peripheral strobes STB_n and ACK_n plus CPU access pulses, and generates the port-stage controls strobe (input latch enable) and hiz (mode 2 bus release). It also produces the port C status bits IBF, OBF_n, INTR and INTE. It sits directly upstream of the group's data port stage and beside the port C status mux.

Parameters:
SYNC_STAGES, 2, synchronizer depth for stb_n/ack_n (min 1).

Ports:
clock  input  1  system clock; all state updates on falling edge
reset  input  1  asynchronous, active-high
mode_select_reg  input  2  00 = mode 0, 01 = mode 1, 1x = mode 2
port_io_reg  input  1  mode 1 direction: 1 = input, 0 = output
update_mode  input  1  control word written (1-clock pulse)
wr_start  input  1  CPU write to this port began (1-clock pulse)
wr_end  input  1  CPU write to this port completed (1-clock pulse)
rd_start  input  1  CPU read of this port began (1-clock pulse)
rd_end  input  1  CPU read of this port completed (1-clock pulse)
inte_in_wr  input  1  port C bit set/reset targeting INTE(input)
inte_out_wr  input  1  port C bit set/reset targeting INTE(output)
inte_data  input  1  value for the INTE write
stb_n  input  1  peripheral strobe, async, active-low
ack_n  input  1  peripheral acknowledge, async, active-low
strobe  output  1  to port stage: latch port_in while 1
hiz  output  1  to port stage: 1 = release bus (mode 2)
ibf  output  1  input buffer full
obf_n  output  1  output buffer full, active-low
intr  output  1  interrupt request
inte_in  output  1  INTE(input) readback
inte_out  output  1  INTE(output) readback

Behaviour:
- Reset values: strobe 0, hiz 1, ibf 0, obf_n 1, intr 0, inte_in 0, inte_out 0. Synchronizer and edge-history flops reset to 1 (inactive).
- Sync: stb_n and ack_n each pass through a SYNC_STAGES flop chain, giving stb_s and ack_s. Edge detect compares these against 1-flop history.
  - fall = prev & ~cur; rise = ~prev & cur.
- in_en = mode 2 or (mode 1 & port_io_reg). out_en = mode 2 or (mode 1 & ~port_io_reg). Mode 0: in_en = out_en = 0.
- strobe = in_en & ~stb_s (combinational).
  - stb_n first sampled low at edge N gives strobe = 1 after edge N+SYNC_STAGES-1 and ibf = 1 after edge N+SYNC_STAGES.
- hiz = ~(mode 2 & ~ack_s). Drive the bus only while ACK is active in mode 2; hiz = 1 in all other modes.
- ibf: set on stb fall (in_en); cleared on rd_end. Simultaneous set and clear: set wins.
- obf_n: driven 0 on wr_end (out_en); driven 1 on ack fall. Simultaneous: wr_end wins (obf_n = 0).
- pend_in: set on stb rise when in_en & (ibf | stb fall same cycle); cleared on rd_start. Set wins over clear.
- pend_out: set on ack rise when out_en & obf_n = 1 (after same-cycle update); cleared on wr_start. Set wins over clear.
- intr = (inte_in & pend_in) | (inte_out & pend_out), combinational.
  - Clearing an INTE masks intr immediately.
  - Setting an INTE while its flag is pending asserts intr the next cycle.
- inte_in/inte_out: loaded from inte_data on their write pulse, regardless of mode.
- update_mode (synchronous, highest priority after reset) clears ibf, pend_in, pend_out, inte_in, inte_out and sets obf_n = 1. Synchronizers keep running.
- Events in a disabled direction are ignored, and flags hold their cleared values.
- Reset mid-handshake returns everything to reset values immediately.

Optional Feature:
KF8255_HS_SYNC_EN
- Defined: SYNC_STAGES-deep synchronizer as above.
- Undefined: single sampling flop (SYNC_STAGES ignored, treated as 1). strobe asserts after edge N, ibf after edge N+1.

Test Plan:
- Reset, mode 01, port_io_reg = 1, inte_in = 1; stb_n low at edge 10 for 4 clocks -> strobe = 1 after edge 11, ibf = 1 after edge 12; on stb_n rise intr = 1; rd_start -> intr = 0; rd_end -> ibf = 0.
- Mode 01 output, inte_out = 1; wr_end -> obf_n = 0; ack_n low 3 clocks -> obf_n = 1 two edges after; ack_n rise -> intr = 1; wr_start -> intr = 0.
- Mode 1x: ack_n low -> hiz = 0 after SYNC_STAGES edges, back to 1 on release; stb_n pulse sets ibf; intr asserts from either side.
- pend_in set with inte_in = 0 -> intr = 0; inte_in_wr with data 1 -> intr = 1; data 0 -> intr = 0.
- Simultaneous stb fall and rd_end -> ibf stays 1; simultaneous wr_end and ack fall -> obf_n = 0; update_mode with ibf = 1 and intr = 1 -> all cleared, obf_n = 1.
- Mode 00: stb_n/ack_n toggling -> strobe 0, hiz 1, ibf 0, obf_n 1, intr 0.
